match_scoreboard: RTL

Downstream of the tic-tac-toe game core: consumes its board (`pos0`–`pos8`) and `winner` outputs. Per game it:
- scores the result (P1 win, P2 win or draw);
- holds the final board for a display interval;
- pulses `game_reset` to clear the board for the next game.

Across games it keeps per-player and draw counters. It declares a match winner when a player reaches `MAX_SCORE`, and freezes until `new_match`. `game_reset` is ORed with the system reset at the game core's `reset` input.

---
 rtl/match_scoreboard_if.sv | 32 +++
 rtl/match_scoreboard.sv | 87 ++++++++
 2 files changed

// File: rtl/match_scoreboard_if.sv
// match_scoreboard_if: board/result inputs from the game core and scoreboard outputs.
// ILLEGAL_COUNT_EN adds illegal_count.
interface match_scoreboard_if #(parameter int SCORE_W = 4);
  logic [1:0] pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8;
  logic [1:0] winner;
  logic illegal_move;
  logic new_match;
  logic game_reset;
  logic [SCORE_W-1:0] p1_score, p2_score, draws;
  logic match_over;
  logic [1:0] match_winner;
`ifdef ILLEGAL_COUNT_EN
  logic [SCORE_W-1:0] illegal_count;
  modport master(
    output pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, winner, illegal_move, new_match,
    input game_reset, p1_score, p2_score, draws, match_over, match_winner, illegal_count
  );
  modport slave(
    input pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, winner, illegal_move, new_match,
    output game_reset, p1_score, p2_score, draws, match_over, match_winner, illegal_count
  );
`else
  modport master(
    output pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, winner, illegal_move, new_match,
    input game_reset, p1_score, p2_score, draws, match_over, match_winner
  );
  modport slave(
    input pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, winner, illegal_move, new_match,
    output game_reset, p1_score, p2_score, draws, match_over, match_winner
  );
`endif
endinterface

// File: rtl/match_scoreboard.sv
// match_scoreboard: scores tic-tac-toe games, holds the final board, clears it and tracks the match.
// Optional ILLEGAL_COUNT_EN counts rising edges of illegal_move.
module match_scoreboard #(
  parameter int HOLD_CYCLES = 8,
  parameter int SCORE_W = 4,
  parameter int MAX_SCORE = 3
) (
  input logic clk,
  input logic reset,
  match_scoreboard_if.slave sb
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SCORE_W-1:0] score_max = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] one = SCORE_W'(1);
  typedef enum logic [2:0] {PLAY, HOLD, CLEAR, SETTLE, MATCH_END} state_t;
  state_t state;
  logic [HW-1:0] hold_cnt;
  logic full, p1_win, p2_win, draw;
  always_comb begin
    full = |sb.pos0 && |sb.pos1 && |sb.pos2 && |sb.pos3 && |sb.pos4 &&
           |sb.pos5 && |sb.pos6 && |sb.pos7 && |sb.pos8;
    p1_win = sb.winner == 2'b01;
    p2_win = sb.winner == 2'b10;
    draw = full && !p1_win && !p2_win;
  end
  // game_reset lags CLEAR by one cycle so the pulse is a clean register output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PLAY;
      hold_cnt <= '0;
      sb.game_reset <= 1'b0;
      sb.p1_score <= '0;
      sb.p2_score <= '0;
      sb.draws <= '0;
      sb.match_over <= 1'b0;
      sb.match_winner <= 2'b00;
    end else begin
      sb.game_reset <= state == CLEAR;
      case (state)
        PLAY: begin
          if (p1_win && sb.p1_score != score_max) sb.p1_score <= sb.p1_score + one;
          if (p2_win && sb.p2_score != score_max) sb.p2_score <= sb.p2_score + one;
          if (draw && sb.draws != '1) sb.draws <= sb.draws + one;
          if (p1_win || p2_win || draw) begin
            state <= HOLD;
            hold_cnt <= HW'(HOLD_CYCLES - 1);
          end
        end
        HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
          else if (sb.p1_score == score_max || sb.p2_score == score_max) begin
            state <= MATCH_END;
            sb.match_over <= 1'b1;
            sb.match_winner <= sb.p1_score == score_max ? 2'b01 : 2'b10;
          end else state <= CLEAR;
        end
        CLEAR: state <= SETTLE;
        SETTLE: state <= PLAY;
        MATCH_END: begin
          if (sb.new_match) begin
            state <= CLEAR;
            sb.p1_score <= '0;
            sb.p2_score <= '0;
            sb.draws <= '0;
            sb.match_over <= 1'b0;
            sb.match_winner <= 2'b00;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end
`ifdef ILLEGAL_COUNT_EN
  logic illegal_prev;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_prev <= 1'b0;
      sb.illegal_count <= '0;
    end else begin
      illegal_prev <= sb.illegal_move;
      if (state == MATCH_END && sb.new_match) sb.illegal_count <= '0;
      else if (state != MATCH_END && sb.illegal_move && !illegal_prev && sb.illegal_count != '1)
        sb.illegal_count <= sb.illegal_count + one;
    end
  end
`endif
endmodule
